// File: rtl/button_events_pkg.sv
// Shared types and defaults for the button event generator.
package button_events_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  localparam int DEF_HOLD_CYCLES   = 500;
  localparam int DEF_REPEAT_CYCLES = 100;
  localparam int CNT_W             = 16;

endpackage

// File: rtl/button_events_repeat_channel.sv
// Press-and-hold auto-repeat FSM for one button; pulse one cycle after the rising sample.
// Pulses again after HOLD_CYCLES, then every REPEAT_CYCLES; inhibit forces IDLE.
module repeat_channel
  import button_events_pkg::*;
#(
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  input  logic rise,
  input  logic inhibit,
  output logic pulse
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  rpt_state_t       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (inhibit) begin
        // Conflict parks the channel; only a fresh rising edge restarts it.
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              pulse <= 1'b1;
              cnt   <= '0;
              state <= HOLD;
            end
          end
          HOLD: begin
            if (!level) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == HOLD_LAST) begin
              pulse <= 1'b1;
              cnt   <= '0;
              state <= REPEAT;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          REPEAT: begin
            if (!level) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == REPEAT_LAST) begin
              pulse <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/button_events.sv
// Turns debounced button levels into one-cycle event pulses (latency 1).
// plus/minus auto-repeat while held and are suppressed while both are pressed.
module button_events
  import button_events_pkg::*;
#(
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic debounced_plus_button,
  input  logic debounced_minus_button,
  input  logic debounced_program_button,
  input  logic debounced_set_alarm_button,
  input  logic debounced_turn_off_alarm_button,
  output logic plus_pulse,
  output logic minus_pulse,
  output logic program_pulse,
  output logic set_alarm_pulse,
  output logic turn_off_alarm_pulse
);

  // Bit order: plus, minus, program, set_alarm, turn_off_alarm.
  logic [4:0] cur;
  logic [4:0] prev;
  logic [4:0] rise;
  logic       inhibit;

  assign cur = {debounced_plus_button, debounced_minus_button, debounced_program_button,
                debounced_set_alarm_button, debounced_turn_off_alarm_button};
  assign rise    = cur & ~prev;
  assign inhibit = debounced_plus_button & debounced_minus_button;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev                 <= '0;
      program_pulse        <= 1'b0;
      set_alarm_pulse      <= 1'b0;
      turn_off_alarm_pulse <= 1'b0;
    end else begin
      prev                 <= cur;
      program_pulse        <= rise[2];
      set_alarm_pulse      <= rise[1];
      turn_off_alarm_pulse <= rise[0];
    end
  end

  repeat_channel #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_plus (
    .clk    (clk),
    .rst    (rst),
    .level  (debounced_plus_button),
    .rise   (rise[4]),
    .inhibit(inhibit),
    .pulse  (plus_pulse)
  );

  repeat_channel #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_minus (
    .clk    (clk),
    .rst    (rst),
    .level  (debounced_minus_button),
    .rise   (rise[3]),
    .inhibit(inhibit),
    .pulse  (minus_pulse)
  );

endmodule

// File: tb/tb_button_events.sv
// Scoreboard bench for button_events with HOLD_CYCLES=5, REPEAT_CYCLES=3.
module tb_button_events;

  localparam int H = 5;
  localparam int R = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] btn = '0;  // plus, minus, program, set_alarm, turn_off_alarm
  logic plus_pulse, minus_pulse, program_pulse, set_alarm_pulse, turn_off_alarm_pulse;

  always #5 clk = ~clk;

  button_events #(.HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .debounced_plus_button          (btn[4]),
    .debounced_minus_button         (btn[3]),
    .debounced_program_button       (btn[2]),
    .debounced_set_alarm_button     (btn[1]),
    .debounced_turn_off_alarm_button(btn[0]),
    .plus_pulse                     (plus_pulse),
    .minus_pulse                    (minus_pulse),
    .program_pulse                  (program_pulse),
    .set_alarm_pulse                (set_alarm_pulse),
    .turn_off_alarm_pulse           (turn_off_alarm_pulse)
  );

  typedef struct {
    string      tag;
    logic [4:0] exp;
  } sb_entry_t;

  sb_entry_t  sb_q[$];
  int         n_vec  = 0;
  int         n_miss = 0;
  string      cur_tag = "init";
  int         tick = 0;

  // Reference model state: last sample and length of the current valid hold (-1 = none).
  logic [4:0] m_prev = '0;
  int         m_run[2] = '{-1, -1};

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] model_step(input logic r, input logic [4:0] in);
    logic [4:0] e;
    logic       conflict;
    e = '0;
    if (r) begin
      m_prev = '0;
      m_run  = '{-1, -1};
      return e;
    end
    conflict = in[4] & in[3];
    for (int c = 0; c < 2; c++) begin
      int b;
      b = 4 - c;
      if (conflict || !in[b]) begin
        m_run[c] = -1;
      end else if (m_run[c] >= 0) begin
        m_run[c]++;
        e[b] = (m_run[c] == H) || (m_run[c] > H && ((m_run[c] - H) % R) == 0);
      end else if (!m_prev[b]) begin
        m_run[c] = 0;
        e[b] = 1'b1;
      end
    end
    e[2:0] = in[2:0] & ~m_prev[2:0];
    m_prev = in;
    return e;
  endfunction

  task automatic pop_check();
    sb_entry_t s;
    if (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      chk(s.tag, {plus_pulse, minus_pulse, program_pulse, set_alarm_pulse, turn_off_alarm_pulse},
          s.exp);
    end
  endtask

  // One clock: check the previous edge's outputs, then drive and predict the next edge.
  task automatic step(input logic r, input logic [4:0] in);
    sb_entry_t s;
    @(negedge clk);
    pop_check();
    rst = r;
    btn = in;
    tick++;
    s.tag = $sformatf("%s@%0d", cur_tag, tick);
    s.exp = model_step(r, in);
    sb_q.push_back(s);
  endtask

  task automatic hold(input logic [4:0] in, input int n);
    for (int i = 0; i < n; i++) step(1'b0, in);
  endtask

  initial begin
    cur_tag = "reset";
    step(1'b1, 5'b00000);
    step(1'b1, 5'b11111);
    step(1'b1, 5'b00000);

    cur_tag = "program_hold"; tick = 0;
    hold(5'b00100, 10);
    hold(5'b00000, 3);

    cur_tag = "plus_repeat"; tick = 0;
    hold(5'b10000, 11);
    hold(5'b00000, 3);

    cur_tag = "minus_short"; tick = 0;
    hold(5'b01000, 4);
    hold(5'b00000, 2);
    hold(5'b01000, 2);
    hold(5'b00000, 3);

    cur_tag = "conflict"; tick = 0;
    hold(5'b10000, 3);
    hold(5'b11000, 10);
    hold(5'b10000, 12);
    hold(5'b00000, 3);

    cur_tag = "reset_mid_repeat"; tick = 0;
    hold(5'b10000, 12);
    step(1'b1, 5'b10000);
    hold(5'b10000, 12);
    hold(5'b00000, 3);

    cur_tag = "alarm_pair"; tick = 0;
    hold(5'b00011, 4);
    hold(5'b00000, 2);

    cur_tag = "same_edge_pm"; tick = 0;
    hold(5'b11000, 4);
    hold(5'b00000, 2);

    cur_tag = "random"; tick = 0;
    begin
      logic [4:0] v;
      v = '0;
      for (int i = 0; i < 300; i++) begin
        for (int b = 0; b < 5; b++)
          if ($urandom_range(0, 7) == 0) v[b] = ~v[b];
        step($urandom_range(0, 99) == 0, v);
      end
    end
    hold(5'b00000, 2);

    @(negedge clk);
    pop_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
